// File: rtl/operand_bus_arbiter_pkg.sv
// Shared types and constants for the four-way operand bus arbiter.
// Build option: BURST_LIMIT_EN caps the words per tenure at BURST_MAX.
package operand_bus_arbiter_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_e;

    localparam logic [1:0] REQ_A = 2'd0;
    localparam logic [1:0] REQ_B = 2'd1;
    localparam logic [1:0] REQ_C = 2'd2;
    localparam logic [1:0] REQ_D = 2'd3;

    localparam int WIDTH_DEF = 16;

endpackage

// File: rtl/operand_bus_arbiter_if.sv
// Requester/downstream bundle for the operand bus arbiter.
// master = requester side, slave = arbiter side.
interface operand_bus_arbiter_if
    import operand_bus_arbiter_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF
);
    logic [3:0]       Req;
    logic [3:0]       Last;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic [WIDTH-1:0] C;
    logic [WIDTH-1:0] D;
    logic             Out_ready;
    logic [3:0]       Grant;
    logic [1:0]       Sel;
    logic [WIDTH-1:0] Out;
    logic             Out_valid;
    logic             Busy;

    modport master (
        output Req, Last, A, B, C, D, Out_ready,
        input  Grant, Sel, Out, Out_valid, Busy
    );

    modport slave (
        input  Req, Last, A, B, C, D, Out_ready,
        output Grant, Sel, Out, Out_valid, Busy
    );
endinterface

// File: rtl/operand_bus_arbiter_rr_pick4.sv
// Round-robin picker: first set request searching upward from ptr+1.
module rr_pick4 (
    input  logic [3:0] req_i,
    input  logic [1:0] ptr_i,
    output logic [3:0] onehot_o,
    output logic [1:0] idx_o,
    output logic       any_o
);
    logic [1:0] j;

    always_comb begin
        onehot_o = '0;
        idx_o    = '0;
        any_o    = 1'b0;
        j        = '0;
        for (int i = 1; i <= 4; i++) begin
            j = ptr_i + 2'(i);
            if (!any_o && req_i[j]) begin
                any_o       = 1'b1;
                idx_o       = j;
                onehot_o[j] = 1'b1;
            end
        end
    end
endmodule

// File: rtl/operand_bus_arbiter.sv
// Four-requester round-robin arbiter driving a registered operand bus.
// Build option: BURST_LIMIT_EN ends each tenure after BURST_MAX words.
module operand_bus_arbiter
    import operand_bus_arbiter_pkg::*;
#(
    parameter int WIDTH     = WIDTH_DEF,
    parameter int BURST_MAX = 4
) (
    input  logic                  CLK,
    input  logic                  Reset_n,
    operand_bus_arbiter_if.slave  bus
);
    state_e           state_q, state_d;
    logic [3:0]       grant_q, grant_d;
    logic [1:0]       sel_q, sel_d;
    logic [1:0]       ptr_q, ptr_d;
    logic [WIDTH-1:0] out_q, out_d;
    logic             ov_q, ov_d;

    logic [3:0]       pick_oh;
    logic [1:0]       pick_idx;
    logic             pick_any;
    logic [WIDTH-1:0] word;
    logic             req_sel;
    logic             last_sel;
    logic             xfer;
    logic             burst_end;
    logic             tenure_end;

    rr_pick4 u_pick (
        .req_i    (bus.Req),
        .ptr_i    (ptr_q),
        .onehot_o (pick_oh),
        .idx_o    (pick_idx),
        .any_o    (pick_any)
    );

    always_comb begin
        word = bus.A;
        unique case (sel_q)
            REQ_A: word = bus.A;
            REQ_B: word = bus.B;
            REQ_C: word = bus.C;
            REQ_D: word = bus.D;
        endcase
    end

    assign req_sel  = bus.Req[sel_q];
    assign last_sel = bus.Last[sel_q];
    assign xfer     = (state_q == GRANT) && req_sel
                      && (!ov_q || bus.Out_ready);

`ifdef BURST_LIMIT_EN
    localparam int CW = (BURST_MAX > 4) ? $clog2(BURST_MAX) : 2;
    logic [CW-1:0] cnt_q, cnt_d;

    assign burst_end = (cnt_q == CW'(BURST_MAX - 1));

    always_comb begin
        cnt_d = cnt_q;
        if (state_q == IDLE)
            cnt_d = '0;
        else if (xfer)
            cnt_d = cnt_q + CW'(1);
    end

    always_ff @(posedge CLK or negedge Reset_n) begin
        if (!Reset_n)
            cnt_q <= '0;
        else
            cnt_q <= cnt_d;
    end
`else
    assign burst_end = 1'b0;
`endif

    // A stalled grantee that withdraws its request gives up the bus.
    assign tenure_end = (state_q == GRANT)
                        && (xfer ? (last_sel || burst_end) : !req_sel);

    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        sel_d   = sel_q;
        ptr_d   = ptr_q;
        out_d   = out_q;
        ov_d    = ov_q;
        if (xfer) begin
            out_d = word;
            ov_d  = 1'b1;
        end else if (bus.Out_ready) begin
            ov_d  = 1'b0;
        end
        unique case (state_q)
            IDLE: begin
                if (pick_any) begin
                    state_d = GRANT;
                    grant_d = pick_oh;
                    sel_d   = pick_idx;
                end
            end
            GRANT: begin
                if (tenure_end) begin
                    state_d = IDLE;
                    grant_d = '0;
                    ptr_d   = sel_q;
                end
            end
        endcase
    end

    always_ff @(posedge CLK or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q <= IDLE;
            grant_q <= '0;
            sel_q   <= REQ_A;
            ptr_q   <= REQ_D;
            out_q   <= '0;
            ov_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            sel_q   <= sel_d;
            ptr_q   <= ptr_d;
            out_q   <= out_d;
            ov_q    <= ov_d;
        end
    end

    assign bus.Grant     = grant_q;
    assign bus.Sel       = sel_q;
    assign bus.Out       = out_q;
    assign bus.Out_valid = ov_q;
    assign bus.Busy      = (state_q == GRANT);
endmodule

// File: tb/tb_operand_bus_arbiter.sv
// Directed bench for operand_bus_arbiter: vector table plus corner sequences.
module tb_operand_bus_arbiter;
    logic CLK = 1'b0;
    logic Reset_n;
    int   pass_cnt = 0;
    int   tot_cnt  = 0;

    always #5 CLK = ~CLK;

    operand_bus_arbiter_if #(.WIDTH(16)) bus ();

    operand_bus_arbiter #(
        .WIDTH     (16),
        .BURST_MAX (4)
    ) dut (
        .CLK     (CLK),
        .Reset_n (Reset_n),
        .bus     (bus)
    );

    typedef struct {
        logic [3:0]  req;
        logic [3:0]  last;
        logic        rdy;
        logic [3:0]  g;
        logic        ov;
        logic [15:0] out;
        logic        busy;
    } vec_t;

    vec_t tv[12];

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        tot_cnt++;
        if (act !== exp)
            $display("FAIL %s: got %h want %h", nm, act, exp);
        else
            pass_cnt++;
    endtask

    task automatic chk_all(input string nm, input logic [3:0] g,
                           input logic ov, input logic [15:0] out,
                           input logic busy);
        chk({nm, ".grant"}, 32'(bus.Grant), 32'(g));
        chk({nm, ".ov"}, 32'(bus.Out_valid), 32'(ov));
        chk({nm, ".out"}, 32'(bus.Out), 32'(out));
        chk({nm, ".busy"}, 32'(bus.Busy), 32'(busy));
    endtask

    task automatic tick;
        @(posedge CLK);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        tv[0]  = '{4'b0001, 4'b0001, 1'b1, 4'b0001, 1'b0, 16'h0000, 1'b1};
        tv[1]  = '{4'b0001, 4'b0001, 1'b1, 4'b0000, 1'b1, 16'h1234, 1'b0};
        tv[2]  = '{4'b0000, 4'b0000, 1'b1, 4'b0000, 1'b0, 16'h1234, 1'b0};
        tv[3]  = '{4'b1111, 4'b1111, 1'b1, 4'b0010, 1'b0, 16'h1234, 1'b1};
        tv[4]  = '{4'b1111, 4'b1111, 1'b1, 4'b0000, 1'b1, 16'h2222, 1'b0};
        tv[5]  = '{4'b1111, 4'b1111, 1'b1, 4'b0100, 1'b0, 16'h2222, 1'b1};
        tv[6]  = '{4'b1111, 4'b1111, 1'b1, 4'b0000, 1'b1, 16'h3333, 1'b0};
        tv[7]  = '{4'b1111, 4'b1111, 1'b1, 4'b1000, 1'b0, 16'h3333, 1'b1};
        tv[8]  = '{4'b1111, 4'b1111, 1'b1, 4'b0000, 1'b1, 16'h4444, 1'b0};
        tv[9]  = '{4'b1111, 4'b1111, 1'b1, 4'b0001, 1'b0, 16'h4444, 1'b1};
        tv[10] = '{4'b1111, 4'b1111, 1'b1, 4'b0000, 1'b1, 16'h1234, 1'b0};
        tv[11] = '{4'b0000, 4'b0000, 1'b1, 4'b0000, 1'b0, 16'h1234, 1'b0};

        Reset_n       = 1'b0;
        bus.Req       = '0;
        bus.Last      = '0;
        bus.Out_ready = 1'b0;
        bus.A         = 16'h1234;
        bus.B         = 16'h2222;
        bus.C         = 16'h3333;
        bus.D         = 16'h4444;
        #12;
        chk_all("reset", 4'b0000, 1'b0, 16'h0000, 1'b0);
        chk("reset.sel", 32'(bus.Sel), 32'd0);
        Reset_n = 1'b1;

        for (int i = 0; i < 12; i++) begin
            bus.Req       = tv[i].req;
            bus.Last      = tv[i].last;
            bus.Out_ready = tv[i].rdy;
            tick();
            chk_all($sformatf("v%0d", i), tv[i].g, tv[i].ov,
                    tv[i].out, tv[i].busy);
        end

        bus.Req  = 4'b0010;
        bus.Last = 4'b0000;
        bus.B    = 16'h0B01;
        tick();
        chk_all("bp.grant", 4'b0010, 1'b0, 16'h1234, 1'b1);
        chk("bp.sel", 32'(bus.Sel), 32'd1);
        tick();
        chk_all("bp.w1", 4'b0010, 1'b1, 16'h0B01, 1'b1);
        bus.Out_ready = 1'b0;
        bus.B         = 16'h0B02;
        for (int k = 0; k < 3; k++) begin
            tick();
            chk_all($sformatf("bp.stall%0d", k), 4'b0010, 1'b1,
                    16'h0B01, 1'b1);
        end
        bus.Out_ready = 1'b1;
        tick();
        chk_all("bp.w2", 4'b0010, 1'b1, 16'h0B02, 1'b1);
        bus.B = 16'h0B03;
        tick();
        chk_all("bp.w3", 4'b0010, 1'b1, 16'h0B03, 1'b1);
        bus.B    = 16'h0B04;
        bus.Last = 4'b0010;
        tick();
        chk_all("bp.w4", 4'b0000, 1'b1, 16'h0B04, 1'b0);

        bus.Out_ready = 1'b0;
        bus.Last      = 4'b0000;
        bus.Req       = 4'b1000;
        tick();
        chk_all("d.grant", 4'b1000, 1'b1, 16'h0B04, 1'b1);
        chk("d.sel", 32'(bus.Sel), 32'd3);
        bus.Req = 4'b0000;
        tick();
        chk_all("d.drop", 4'b0000, 1'b1, 16'h0B04, 1'b0);

        bus.Req       = 4'b0101;
        bus.Out_ready = 1'b1;
        tick();
        chk_all("bl.grant", 4'b0001, 1'b0, 16'h0B04, 1'b1);
        for (int k = 1; k <= 4; k++) begin
            bus.A = 16'hA000 + 16'(k);
            tick();
`ifdef BURST_LIMIT_EN
            chk_all($sformatf("bl.w%0d", k), (k == 4) ? 4'b0000 : 4'b0001,
                    1'b1, 16'hA000 + 16'(k), (k == 4) ? 1'b0 : 1'b1);
`else
            chk_all($sformatf("bl.w%0d", k), 4'b0001, 1'b1,
                    16'hA000 + 16'(k), 1'b1);
`endif
        end
        bus.A = 16'hA005;
        tick();
`ifdef BURST_LIMIT_EN
        chk_all("bl.next", 4'b0100, 1'b0, 16'hA004, 1'b1);
`else
        chk_all("bl.next", 4'b0001, 1'b1, 16'hA005, 1'b1);
`endif

        #3;
        Reset_n = 1'b0;
        #1;
        chk_all("rst.mid", 4'b0000, 1'b0, 16'h0000, 1'b0);
        chk("rst.sel", 32'(bus.Sel), 32'd0);
        bus.Req  = 4'b1111;
        bus.Last = 4'b1111;
        #1;
        Reset_n = 1'b1;
        tick();
        chk_all("rst.regrant", 4'b0001, 1'b0, 16'h0000, 1'b1);
        tick();
        chk_all("rst.w", 4'b0000, 1'b1, 16'hA005, 1'b0);

        $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
        $finish;
    end
endmodule
